merge2_drive_fifo_bridge: RTL and testbench

- Sits directly downstream of the two-way drive/free wait-merge stage.
- Captures each merged drive pulse and its concatenated {data1,data0} word into a synchronous FIFO, then re-presents it as a clocked valid/ready stream.
- Returns a single-cycle free pulse upstream once the word is safely stored, closing the drive/free loop.
- Bridges the self-timed merge control onto the single-clock datapath.

---
 rtl/merge2_bridge_pkg.sv | 23 ++
 rtl/merge2_drive_fifo_bridge_sync_fifo_core.sv | 71 +++++++
 rtl/merge2_drive_fifo_bridge.sv | 102 ++++++++++
 tb/tb_merge2_drive_fifo_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge2_bridge_pkg.sv
// Shared widths and word type for the merge2 drive/free FIFO bridge.
package merge2_bridge_pkg;

  localparam int unsigned BRIDGE_DATA_WIDTH = 32;
  localparam int unsigned BRIDGE_DEPTH      = 4;
  localparam int unsigned BRIDGE_WORD_W     = 2 * BRIDGE_DATA_WIDTH;
  localparam int unsigned BRIDGE_PTR_W      = $clog2(BRIDGE_DEPTH);
  localparam int unsigned BRIDGE_CNT_W      = BRIDGE_PTR_W + 1;

  // Merged {lane1,lane0} word at the default lane width
  typedef logic [BRIDGE_WORD_W-1:0] word_t;

  // Pointer width for a power-of-two depth
  function automatic int unsigned calc_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so a full FIFO reads as DEPTH
  function automatic int unsigned calc_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/merge2_drive_fifo_bridge_sync_fifo_core.sv
// Single-clock FIFO core with registered count-based full/empty flags.
module sync_fifo_core
  import merge2_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = BRIDGE_WORD_W,
  parameter int unsigned DEPTH = BRIDGE_DEPTH,
  localparam int unsigned PTR_W = calc_ptr_w(DEPTH),
  localparam int unsigned CNT_W = calc_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_wr;
  logic             w_rd;
  logic [CNT_W-1:0] w_count_next;

  assign w_wr = i_wr_en & ~r_full;
  assign w_rd = i_rd_en & ~r_empty;

  // Occupancy after this edge's write/read
  always_comb begin
    w_count_next = r_count;
    unique case ({w_wr, w_rd})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage, pointers, count and flags; storage cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/merge2_drive_fifo_bridge.sv
// Drive/free wait-merge to valid/ready bridge: captures each drive edge's word,
// stores it in a FIFO and returns a one-cycle free pulse once it is written.
// Optional: define MERGE2_BRIDGE_DRIVE_SYNC_EN to pass i_drive through a
// two-flop synchroniser before edge detection.
module merge2_drive_fifo_bridge
  import merge2_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BRIDGE_DATA_WIDTH,
  parameter int unsigned DEPTH      = BRIDGE_DEPTH,
  localparam int unsigned WORD_W    = 2 * DATA_WIDTH,
  localparam int unsigned CNT_W     = calc_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  output logic              o_free,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_err_overrun
);

  logic              w_drv_s;
  logic              w_drive_edge;
  logic              w_write;
  logic              w_accept;
  logic              w_overrun;
  logic              w_full;
  logic              w_empty;

  logic              r_drv_prev;
  logic              r_pending;
  logic [WORD_W-1:0] r_hold;
  logic              r_free;
  logic              r_err;

`ifdef MERGE2_BRIDGE_DRIVE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser; resets high so a drive held across reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_drive;
      r_sync2 <= r_sync1;
    end
  end

  assign w_drv_s = r_sync2;
`else
  assign w_drv_s = i_drive;
`endif

  assign w_drive_edge = w_drv_s & ~r_drv_prev;
  // Held word drains only into a slot that was free before this edge
  assign w_write      = r_pending & ~w_full;
  // A new edge is accepted when nothing is held or the held word leaves this edge
  assign w_accept     = w_drive_edge & (~r_pending | w_write);
  assign w_overrun    = w_drive_edge & r_pending & ~w_write;

  // Edge history, hold register, pending flag, free pulse and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drv_prev <= 1'b1;
      r_pending  <= 1'b0;
      r_hold     <= '0;
      r_free     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_drv_prev <= w_drv_s;
      r_free     <= w_write;
      r_pending  <= w_accept | (r_pending & ~w_write);
      if (w_accept)  r_hold <= i_data;
      if (w_overrun) r_err  <= 1'b1;
    end
  end

  sync_fifo_core #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_write),
    .i_wr_data (r_hold),
    .i_rd_en   (i_ready),
    .o_rd_data (o_data),
    .o_count   (o_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_free        = r_free;
  assign o_valid       = ~w_empty;
  assign o_err_overrun = r_err;

endmodule

// File: tb/tb_merge2_drive_fifo_bridge.sv
// Bench for merge2_drive_fifo_bridge: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_merge2_drive_fifo_bridge;
  import merge2_bridge_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
`ifdef MERGE2_BRIDGE_DRIVE_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           i_drive;
  logic           o_free;
  word_t          i_data;
  logic           o_valid;
  logic           i_ready;
  word_t          o_data;
  logic [CW-1:0]  o_count;
  logic           o_err_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  merge2_drive_fifo_bridge #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_drive       (i_drive),
    .o_free        (o_free),
    .i_data        (i_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_count       (o_count),
    .o_err_overrun (o_err_overrun)
  );

  // Reference model: a queue of stored words plus one held request
  word_t mq[$];
  bit    m_pend, m_err, m_free, m_d1, m_d2, m_prev;
  word_t m_hold;

  always @(posedge clk) begin
    bit rd, wr, ds, edg;
    int sz;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_err = 0; m_free = 0; m_hold = '0;
      m_d1 = 1; m_d2 = 1; m_prev = 1;
    end else begin
`ifdef MERGE2_BRIDGE_DRIVE_SYNC_EN
      ds = m_d2; m_d2 = m_d1; m_d1 = i_drive;
`else
      ds = i_drive;
`endif
      sz  = mq.size();
      rd  = (sz > 0) && i_ready;
      wr  = m_pend && (sz < int'(DEPTH));
      edg = ds && !m_prev;
      m_prev = ds;
      if (rd) void'(mq.pop_front());
      if (wr) begin
        mq.push_back(m_hold);
        m_pend = 0;
      end
      m_free = wr;
      if (edg) begin
        if (!m_pend) begin
          m_hold = i_data;
          m_pend = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise drive with a word and wait for free; drive is released only if free came
  task automatic handshake(input word_t w, input int max_wait, output bit got);
    got = 0;
    i_data  = w;
    i_drive = 1'b1;
    for (int j = 0; j < max_wait; j++) begin
      @(negedge clk);
      if (o_free === 1'b1) got = 1;
      if (got) break;
    end
    if (got) begin
      tick();
      i_drive = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_drive = 1'b0; i_ready = 1'b0; i_data = '0;
    tick(); tick();
    @(negedge clk);
    total += 5;
    if (o_free !== 1'b0)        begin bad++; $display("FAIL reset_free got=%b want=0", o_free); end
    if (o_valid !== 1'b0)       begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    if (o_count !== '0)         begin bad++; $display("FAIL reset_count got=%0d want=0", o_count); end
    if (o_err_overrun !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", o_err_overrun); end
    if (o_data !== '0)          begin bad++; $display("FAIL reset_data got=%h want=0", o_data); end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) tick();
  endtask

  task automatic test_single();
    word_t w;
    w = 64'h0000_0002_0000_0001;
    i_ready = 1'b1; i_data = w; i_drive = 1'b1;
    for (int j = 0; j <= LAT + 2; j++) begin
      @(negedge clk);
      total++;
      if (o_free !== (j == LAT)) begin bad++; $display("FAIL single_free j=%0d got=%b want=%b", j, o_free, (j == LAT)); end
      if (j == LAT) begin
        total += 3;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", o_valid); end
        if (o_data !== w)     begin bad++; $display("FAIL single_data got=%h want=%h", o_data, w); end
        if (o_count !== CW'(1)) begin bad++; $display("FAIL single_count got=%0d want=1", o_count); end
      end
      if (j == LAT + 1) begin
        total += 2;
        if (o_valid !== 1'b0)   begin bad++; $display("FAIL single_pop_valid got=%b want=0", o_valid); end
        if (o_count !== CW'(0)) begin bad++; $display("FAIL single_pop_count got=%0d want=0", o_count); end
      end
    end
    tick();
    i_drive = 1'b0; i_ready = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    word_t ws [5];
    bit got;
    for (int i = 0; i < 5; i++) ws[i] = {32'(i + 16), 32'hA000_0000 + 32'(i)};
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      handshake(ws[i], LAT + 4, got);
      total++;
      if (got !== 1'b1) begin bad++; $display("FAIL fill_free%0d got=%b want=1", i, got); end
    end
    @(negedge clk);
    total++;
    if (o_count !== CW'(4)) begin bad++; $display("FAIL fill_count got=%0d want=4", o_count); end
    tick();
    handshake(ws[4], 8, got);
    total++;
    if (got !== 1'b0) begin bad++; $display("FAIL fill_fifth_blocked got=%b want=0", got); end
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (o_free !== (j == 1)) begin bad++; $display("FAIL fill_late_free j=%0d got=%b want=%b", j, o_free, (j == 1)); end
      if (j < 2) begin
        total++;
        if (o_count !== CW'(j == 0 ? 3 : 4)) begin bad++; $display("FAIL fill_late_count j=%0d got=%0d want=%0d", j, o_count, (j == 0 ? 3 : 4)); end
      end
    end
    tick();
    i_drive = 1'b0;
    tick();
    i_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || o_data !== ws[i]) begin bad++; $display("FAIL fill_order%0d got=%h want=%h", i, o_data, ws[i]); end
      tick();
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL fill_drained got=%b want=0", o_valid); end
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_simul();
    word_t a, b, c;
    bit got;
    a = 64'h1111_1111_0000_000A; b = 64'h2222_2222_0000_000B; c = 64'h3333_3333_0000_000C;
    i_ready = 1'b0;
    handshake(a, LAT + 4, got);
    handshake(b, LAT + 4, got);
    i_data = c; i_drive = 1'b1;
    for (int j = 0; j < LAT - 1; j++) tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    @(negedge clk);
    total += 3;
    if (o_free !== 1'b1)    begin bad++; $display("FAIL simul_free got=%b want=1", o_free); end
    if (o_count !== CW'(2)) begin bad++; $display("FAIL simul_count got=%0d want=2", o_count); end
    if (o_data !== b)       begin bad++; $display("FAIL simul_head got=%h want=%h", o_data, b); end
    tick();
    i_drive = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (o_data !== b) begin bad++; $display("FAIL simul_first got=%h want=%h", o_data, b); end
    tick();
    @(negedge clk);
    total++;
    if (o_data !== c) begin bad++; $display("FAIL simul_second got=%h want=%h", o_data, c); end
    tick();
    i_ready = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    word_t ws [4];
    word_t a, b;
    word_t seen[$];
    bit got;
    a = 64'hAAAA_AAAA_5555_5555; b = 64'hBBBB_BBBB_6666_6666;
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ws[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 7)};
      handshake(ws[i], LAT + 4, got);
    end
    i_data = a; i_drive = 1'b1; tick();
    i_drive = 1'b0; tick();
    i_data = b; i_drive = 1'b1;
    for (int j = 0; j < LAT + 4; j++) tick();
    @(negedge clk);
    total += 2;
    if (o_err_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", o_err_overrun); end
    if (o_count !== CW'(4))     begin bad++; $display("FAIL overrun_count got=%0d want=4", o_count); end
    tick();
    i_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen.push_back(o_data);
      tick();
    end
    i_ready = 1'b0;
    total++;
    if (seen.size() != 5) begin bad++; $display("FAIL overrun_words got=%0d want=5", seen.size()); end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== (i < 4 ? ws[i] : a)) begin bad++; $display("FAIL overrun_word%0d got=%h want=%h", i, seen[i], (i < 4 ? ws[i] : a)); end
    end
    @(negedge clk);
    total++;
    if (o_err_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", o_err_overrun); end
    tick();
    i_drive = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) handshake({32'h0, 32'hD000_0000 + 32'(i)}, LAT + 4, got);
    i_data = 64'hDEAD_BEEF_CAFE_F00D; i_drive = 1'b1;
    for (int j = 0; j < LAT - 1; j++) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    total += 5;
    if (o_free !== 1'b0)        begin bad++; $display("FAIL rmid_free got=%b want=0", o_free); end
    if (o_valid !== 1'b0)       begin bad++; $display("FAIL rmid_valid got=%b want=0", o_valid); end
    if (o_count !== '0)         begin bad++; $display("FAIL rmid_count got=%0d want=0", o_count); end
    if (o_err_overrun !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b want=0", o_err_overrun); end
    if (o_data !== '0)          begin bad++; $display("FAIL rmid_data got=%h want=0", o_data); end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      total += 2;
      if (o_free !== 1'b0)    begin bad++; $display("FAIL rmid_held_free j=%0d got=%b want=0", j, o_free); end
      if (o_count !== CW'(0)) begin bad++; $display("FAIL rmid_held_count j=%0d got=%0d want=0", j, o_count); end
      tick();
    end
    i_drive = 1'b0;
    for (int j = 0; j < 4; j++) tick();
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(2) == 0) i_drive = ~i_drive;
      i_ready = 1'($urandom_range(1));
      i_data  = {$urandom, $urandom};
      @(negedge clk);
      total += 4;
      if (o_free !== m_free)                 begin bad++; $display("FAIL rand_free n=%0d got=%b want=%b", n, o_free, m_free); end
      if (o_valid !== (mq.size() != 0))      begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, o_valid, (mq.size() != 0)); end
      if (o_count !== CW'(mq.size()))        begin bad++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, o_count, mq.size()); end
      if (o_err_overrun !== m_err)           begin bad++; $display("FAIL rand_err n=%0d got=%b want=%b", n, o_err_overrun, m_err); end
      if (mq.size() != 0) begin
        total++;
        if (o_data !== mq[0]) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, o_data, mq[0]); end
      end
      tick();
    end
    i_drive = 1'b0; i_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
